// File: rtl/ram_uart_tx.sv
// rtl/ram_uart_tx.sv - Wishbone RAM window reader serializing bytes onto a UART TX pin
// Optional even-parity frame bit: define RAM_UART_TX_PARITY_EN.
module ram_uart_tx #(
    parameter logic [31:0] ADR_LL       = 32'h00C00000,
    parameter logic [31:0] ADR_UL       = 32'h00C000FC,
    parameter int          CLKS_PER_BIT = 139
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_start,
    input  logic [31:0] i_adr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef RAM_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int SW = FRAME_BITS - 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_PENULT = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    IDX_STOP   = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    word;
    logic [1:0]     lane;
    logic [15:0]    remaining;
    logic [SW-1:0]  shifter;
    logic [3:0]     bit_idx;
    logic [CW-1:0]  clk_cnt;
    logic           load_pending;
    logic           sending;
    logic           bit_end;
    logic           stop_end;
    logic           final_early;
    logic [31:0]    adr_next;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // Bits following the start bit, LSB first: data, optional parity, stop.
    function automatic logic [SW-1:0] frame_of(input logic [7:0] b);
`ifdef RAM_UART_TX_PARITY_EN
        return {1'b1, ^b, b};
`else
        return {1'b1, b};
`endif
    endfunction

    assign o_wb_we  = 1'b0;
    assign o_wb_sel = 4'b1111;
    assign adr_next = (o_wb_adr == ADR_UL) ? ADR_LL : o_wb_adr + 32'd4;

    always_comb begin
        state_next  = state;
        sending     = (state == SEND) && !load_pending;
        bit_end     = (clk_cnt == BIT_LAST);
        stop_end    = sending && (bit_idx == IDX_STOP) && bit_end;
        // Leaving one cycle early lets the registered o_done land on the stop-bit boundary.
        final_early = sending && (bit_idx == IDX_STOP) && (clk_cnt == BIT_PENULT)
                      && (remaining == 16'd1);
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_len == 16'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (i_wb_ack) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (final_early) begin
                    state_next = DONE;
                end else if (stop_end && (lane == 2'd3)) begin
                    state_next = FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            o_tx         <= 1'b1;
            o_wb_cyc     <= 1'b0;
            o_wb_adr     <= ADR_LL;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            word         <= '0;
            lane         <= '0;
            remaining    <= '0;
            shifter      <= '1;
            bit_idx      <= '0;
            clk_cnt      <= '0;
            load_pending <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy    <= 1'b1;
                        remaining <= i_len;
                        o_wb_adr  <= {i_adr[31:2], 2'b00};
                        lane      <= i_adr[1:0];
                        o_wb_cyc  <= (i_len != 16'd0);
                    end
                end
                FETCH: begin
                    if (i_wb_ack) begin
                        word         <= i_wb_rdt;
                        o_wb_cyc     <= 1'b0;
                        load_pending <= 1'b1;
                    end
                end
                SEND: begin
                    if (load_pending) begin
                        load_pending <= 1'b0;
                        o_tx         <= 1'b0;
                        shifter      <= frame_of(lane_byte(word, lane));
                        bit_idx      <= '0;
                        clk_cnt      <= '0;
                    end else if (final_early) begin
                        clk_cnt <= '0;
                    end else if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == IDX_STOP) begin
                            remaining <= remaining - 16'd1;
                            lane      <= lane + 2'd1;
                            if (lane == 2'd3) begin
                                o_wb_adr <= adr_next;
                                o_wb_cyc <= 1'b1;
                            end else begin
                                // Back-to-back frame: start bit follows the stop bit directly.
                                o_tx    <= 1'b0;
                                shifter <= frame_of(lane_byte(word, lane + 2'd1));
                                bit_idx <= '0;
                            end
                        end else begin
                            o_tx    <= shifter[0];
                            shifter <= {1'b1, shifter[SW-1:1]};
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_uart_tx.sv
// tb/tb_ram_uart_tx.sv - directed scoreboard bench for ram_uart_tx
module tb_ram_uart_tx;

    localparam logic [31:0] LL  = 32'h00C00000;
    localparam logic [31:0] UL  = 32'h00C000FC;
    localparam int          CPB = 139;
`ifdef RAM_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] adr = '0;
    logic [15:0] len = '0;
    logic        busy, done, cyc, we, tx, ack;
    logic [31:0] wb_adr, rdt;
    logic [3:0]  sel;

    ram_uart_tx dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_start  (start),
        .i_adr    (adr),
        .i_len    (len),
        .o_busy   (busy),
        .o_done   (done),
        .o_wb_adr (wb_adr),
        .o_wb_cyc (cyc),
        .o_wb_we  (we),
        .o_wb_sel (sel),
        .i_wb_rdt (rdt),
        .i_wb_ack (ack),
        .o_tx     (tx)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [31:0] mem [64];
    logic [7:0]  exp_q [$];
    logic [31:0] rd_exp_q [$];
    logic [31:0] rd_q [$];
    int          fall_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wishbone RAM responder
    int          ack_delay = 0;
    int          wait_n = 0;
    logic [31:0] cap_adr;
    int          adr_moves = 0;
    int          cyc_cycles = 0;
    int          ack_at = 0;
    int          inject_req = 0;
    int          inject_seen = 0;
    logic [31:0] widx;
    always @(negedge clk) begin
        ack = 1'b0;
        if (cyc) cyc_cycles++;
        if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            ack = 1'b1;
            rdt = 32'hFFFFFFFF;
        end else if (rst || !cyc) begin
            wait_n = 0;
        end else begin
            if (wait_n == 0) cap_adr = wb_adr;
            else if (wb_adr !== cap_adr) adr_moves++;
            if (wait_n == ack_delay) begin
                widx = wb_adr - LL;
                ack = 1'b1;
                rdt = mem[widx[7:2]];
                rd_q.push_back(wb_adr);
                ack_at = cyc_n;
            end
            wait_n++;
        end
    end

    // UART monitor, samples mid-bit
    bit          m_act = 0;
    int          m_cnt = 0;
    logic [FB-1:0] m_bits;
    logic        m_prev = 1'b1;
    int          bytes_rx = 0;
    always @(negedge clk) begin
        if (rst) begin
            m_act = 0;
        end else if (!m_act) begin
            if (m_prev && !tx) begin
                m_act = 1;
                m_cnt = 0;
                fall_q.push_back(cyc_n);
            end
        end else begin
            m_cnt++;
            if ((m_cnt % CPB) == CPB / 2) begin
                m_bits[m_cnt / CPB] = tx;
                if (m_cnt / CPB == FB - 1) begin
                    m_act = 0;
                    bytes_rx++;
                    check("start_bit", 32'(m_bits[0]), 32'd0);
                    check("stop_bit", 32'(m_bits[FB-1]), 32'd1);
`ifdef RAM_UART_TX_PARITY_EN
                    check("parity_bit", 32'(m_bits[9]), 32'(^m_bits[8:1]));
`endif
                    check("rx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("rx_byte", 32'(m_bits[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end
        m_prev = tx;
    end

    int   done_cnt = 0;
    int   done_at = 0;
    logic busy_at_done = 1'b1;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_at = cyc_n;
            busy_at_done = busy;
        end
    end

    int start_at = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [31:0] a, input logic [15:0] l);
        int          off;
        logic [31:0] w;
        off = int'(a - LL);
        for (int k = 0; k < int'(l); k++) begin
            if (k == 0 || (off % 4) == 0) rd_exp_q.push_back(LL + 32'((off / 4) * 4));
            w = mem[off / 4];
            exp_q.push_back(w[8 * (off % 4) +: 8]);
            off = (off + 1) % 256;
        end
        fall_q.delete();
        @(negedge clk);
        adr = a;
        len = l;
        start = 1'b1;
        start_at = cyc_n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int bound);
        int t = 0;
        while (done_cnt == d0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_in_time"}, 32'(t < bound), 32'd1);
        tick(5);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_low_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, "_all_bytes_sent"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_nreads"}, 32'(rd_q.size()), 32'(rd_exp_q.size()));
        while (rd_q.size() != 0 && rd_exp_q.size() != 0)
            check({tag, "_read_adr"}, rd_q.pop_front(), rd_exp_q.pop_front());
        rd_q.delete();
        rd_exp_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0, c0, m0, t;
        for (int i = 0; i < 64; i++) mem[i] = 32'h9E3779B9 * (i + 1);
        mem[0] = 32'h44332211;

        tick(4);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_adr", wb_adr, LL);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_sel", 32'(sel), 32'hF);
        rst = 1'b0;
        tick(3);

        // Three aligned bytes from the first window word
        ack_delay = 0;
        d0 = done_cnt; b0 = bytes_rx;
        launch(LL, 16'd3);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", d0, 3 * FB * CPB + 200);
        check("t1_bytes", 32'(bytes_rx - b0), 32'd3);
        check("t1_done_latency", 32'(done_at - (fall_q.size() != 0 ? fall_q[0] : 0)), 32'(3 * FB * CPB));
        check_reads("t1");

        // Unaligned start two lanes before the window end, wraps to ADR_LL
        d0 = done_cnt; b0 = bytes_rx;
        launch(UL + 32'd2, 16'd4);
        wait_done("t2", d0, 4 * FB * CPB + 200);
        check("t2_bytes", 32'(bytes_rx - b0), 32'd4);
        check_reads("t2");

        // Zero length
        d0 = done_cnt; b0 = bytes_rx; c0 = cyc_cycles;
        launch(LL + 32'd8, 16'd0);
        wait_done("t3", d0, 20);
        check("t3_done_latency", 32'(done_at - start_at), 32'd2);
        check("t3_no_cyc", 32'(cyc_cycles - c0), 32'd0);
        check("t3_no_bytes", 32'(bytes_rx - b0), 32'd0);
        check("t3_tx_idle", 32'(tx), 32'd1);
        check_reads("t3");

        // Start pulse while busy is ignored
        d0 = done_cnt; b0 = bytes_rx;
        launch(LL + 32'd1, 16'd2);
        tick(400);
        adr = LL; len = 16'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t4_busy_mid", 32'(busy), 32'd1);
        wait_done("t4", d0, 2 * FB * CPB + 200);
        tick(2 * FB * CPB);
        check("t4_single_done", 32'(done_cnt - d0), 32'd1);
        check("t4_bytes", 32'(bytes_rx - b0), 32'd2);
        check_reads("t4");

        // Slow acknowledge
        ack_delay = 20;
        d0 = done_cnt; c0 = cyc_cycles; m0 = adr_moves;
        launch(LL + 32'd4, 16'd2);
        t = 0;
        while (fall_q.size() == 0 && t < 200) begin tick(1); t++; end
        check("t5_start_seen", 32'(fall_q.size() != 0), 32'd1);
        if (fall_q.size() != 0) check("t5_start_after_ack", 32'(fall_q[0] - ack_at), 32'd2);
        wait_done("t5", d0, 2 * FB * CPB + 200);
        check("t5_cyc_hold", 32'(cyc_cycles - c0), 32'd21);
        check("t5_adr_stable", 32'(adr_moves - m0), 32'd0);
        check_reads("t5");
        ack_delay = 0;

        // Reset during data bit 4, late ack ignored, then a fresh transfer
        d0 = done_cnt;
        launch(LL, 16'd4);
        t = 0;
        while (fall_q.size() == 0 && t < 200) begin tick(1); t++; end
        check("t6_start_seen", 32'(fall_q.size() != 0), 32'd1);
        tick(5 * CPB + 70);
        check("t6_tx_data_bit4", 32'(tx), 32'(mem[0][4]));
        rst = 1'b1;
        tick(1);
        check("t6_rst_tx", 32'(tx), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cyc", 32'(cyc), 32'd0);
        tick(1);
        rst = 1'b0;
        exp_q.delete(); rd_q.delete(); rd_exp_q.delete();
        inject_req++;
        tick(20);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_late_ack_busy", 32'(busy), 32'd0);
        check("t6_late_ack_cyc", 32'(cyc), 32'd0);
        check("t6_late_ack_tx", 32'(tx), 32'd1);
        b0 = bytes_rx;
        launch(UL + 32'd3, 16'd2);
        wait_done("t6b", d0, 2 * FB * CPB + 200);
        check("t6b_bytes", 32'(bytes_rx - b0), 32'd2);
        check_reads("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_uart_tx.md
Name: ram_uart_tx

Overview:
- Transmit-side counterpart of the BLE receive path: on command, reads a byte stream out of the servant RAM window and serializes it on the BLE UART TX pin.
- Acts as a Wishbone read master on the shared RAM port. The top level muxes it onto the RAM with the same cyc-priority scheme used by the RX write path.
- Replaces the ad-hoc TX logic in the top level.

Parameters:
ADR_LL, 32'h00C00000, first word address of the circular TX window (word aligned)
ADR_UL, 32'h00C000FC, last valid word address of the window, inclusive (word aligned)
CLKS_PER_BIT, 139, wb_clk cycles per UART bit (16 MHz / 115200)

Ports:
i_wb_clk  in  1  system clock; all logic on rising edge
i_wb_rst  in  1  synchronous, active-high reset
i_start  in  1  single-cycle start pulse; sampled only in IDLE
i_adr  in  32  start byte address, latched on accepted i_start; must lie inside the window
i_len  in  16  byte count, latched on accepted i_start
o_busy  out  1  high from the cycle after an accepted start until o_done
o_done  out  1  one-cycle pulse when the last stop bit completes, or immediately for len=0
o_wb_adr  out  32  word address, bits [1:0] always 0
o_wb_cyc  out  1  read request; held until i_wb_ack
o_wb_we  out  1  constant 0
o_wb_sel  out  4  constant 4'b1111
i_wb_rdt  in  32  read data, valid with i_wb_ack
i_wb_ack  in  1  single-cycle acknowledge
o_tx  out  1  UART serial out, idle high, registered

Behaviour:
- Reset values: o_tx=1, o_wb_cyc=0, o_wb_adr=ADR_LL, o_busy=0, o_done=0. FSM goes to IDLE.
- Reset mid-operation:
  - Abort immediately; o_tx returns high on the next edge.
  - A pending cycle is dropped and a late ack is ignored.
  - No o_done.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - On i_start, latch adr/len and set o_busy.
  - len==0: go to DONE; no bus cycle is issued.
  - Otherwise go to FETCH with o_wb_adr = {adr[31:2],2'b00} and byte lane = adr[1:0].
- FETCH:
  - o_wb_cyc=1 from the first cycle in the state.
  - Edge where i_wb_ack=1: latch i_wb_rdt, drop cyc, go to SEND.
  - No timeout; the block waits indefinitely for ack.
- SEND:
  - The cycle after the latch edge, load the frame shifter with byte[lane]. Byte 0 is rdt[7:0] (little-endian).
  - o_tx falls to the start bit on that edge.
  - Frame: start(0), 8 data bits LSB first, stop(1). Each bit lasts exactly CLKS_PER_BIT cycles.
  - After each stop bit: decrement the remaining count and increment the lane.
  - Remaining==0: go to DONE.
  - Lane wraps 3->0: advance the word address, go to FETCH.
  - Otherwise load the next byte with no idle gap between stop and start.
- Address wrap: the word after ADR_UL is ADR_LL. The byte order across the wrap is preserved.
- DONE: o_done=1 for exactly one cycle, o_busy=0 in the same cycle, then IDLE.
- i_start while o_busy is ignored, with no effect on the frame in progress.
- Partial words: leading lanes are skipped when the start address is unaligned. Trailing lanes of the last word are never sent.
- Counters:
  - Bit-time counter: $clog2(CLKS_PER_BIT) bits.
  - Remaining count: 16 bits; no overflow is possible.
  - Address add is 32-bit with wrap compare against ADR_UL.

Optional Feature:
- Macro RAM_UART_TX_PARITY_EN.
- Defined: frame is 11 bits: start, 8 data, even parity bit (XOR of data), stop. The parity bit is sent after data bit 7 and lasts CLKS_PER_BIT.
- Undefined: 8N1 frame as above, with no parity logic synthesized.

Test Plan:
- Word at ADR_LL = 32'h44332211, i_adr=ADR_LL, i_len=3, ack 1 cycle after cyc -> bytes 0x11,0x22,0x33 on o_tx at 139 clk/bit. One bus read at ADR_LL. o_done pulses once, 3*10*139 cycles after the first start-bit edge.
- i_adr=ADR_UL+2, i_len=4 -> reads at ADR_UL then ADR_LL. Sends lanes 2,3 of the first word, then lanes 0,1 of the second.
- i_len=0 -> o_done pulse 2 cycles after i_start, o_wb_cyc never asserted, o_tx stays 1.
- i_start pulsed again mid-frame of an i_len=2 transfer -> ignored; exactly 2 bytes sent, one o_done.
- Ack delayed 20 cycles -> o_wb_cyc held stable with a constant address for 20 cycles; the start bit appears the cycle after the ack latch.
- i_wb_rst asserted during data bit 4 -> o_tx=1 next edge, o_busy=0, no o_done; a fresh start afterwards transmits correctly.
